buffer_fifo: RTL and testbench

BUFFER_FIFO -- requirements
Module: buffer_fifo

---
 rtl/buffer_fifo.sv | 107 ++++++++++
 tb/tb_buffer_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_fifo.sv
// buffer_fifo: synchronous circular-buffer FIFO with a registered read port.
//
// Parameters
//   N      data word width in bits
//   DEPTH  number of storage entries (2, 4 or 8)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   d          write data, captured when a write is accepted
//   w_enable   write request
//   r_enable   read request
//   q          registered read data, holds the most recently read word
//   q_valid    high for the one cycle after an accepted read
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored words
//   overflow   sticky, set by a rejected write
//   underflow  sticky, set by a rejected read
module buffer_fifo #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  d,
  input  logic          w_enable,
  input  logic          r_enable,
  output logic [N-1:0]  q,
  output logic          q_valid,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q;
  logic [N-1:0]  q_q;
  logic          q_valid_q, overflow_q, underflow_q;

  logic          rd_acc, wr_acc;

  // Flags come from the registered count only, never from the requests.
  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  // A full FIFO still takes a write when a read frees the slot in the same
  // edge. An empty FIFO never forwards the incoming word to q.
  always_comb begin
    rd_acc = r_enable && !empty;
    wr_acc = w_enable && (!full || rd_acc);
  end

  // Storage is deliberately not reset; entries are only visible after a write.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wp_q] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      q_valid_q <= rd_acc;
      if (wr_acc) begin
        wp_q <= wp_q + AW'(1);
      end
      if (rd_acc) begin
        // Reads the pre-edge contents, so a full read+write gets the oldest word.
        q_q  <= mem[rp_q];
        rp_q <= rp_q + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - CW'(1);
      end
      if (w_enable && !wr_acc) begin
        overflow_q <= 1'b1;
      end
      if (r_enable && !rd_acc) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_buffer_fifo.sv
// tb_buffer_fifo: self-checking bench for buffer_fifo (N=16, DEPTH=4).
// Directed table of vectors with hand-derived expectations, a pointer-wrap
// sequence, and randomized traffic checked against a queue-based model.
module tb_buffer_fifo;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  d;
  logic          w_enable;
  logic          r_enable;
  logic [N-1:0]  q;
  logic          q_valid;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  buffer_fifo #(
    .N    (N),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .w_enable (w_enable),
    .r_enable (r_enable),
    .q        (q),
    .q_valid  (q_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue, flags as plain variables.
  logic [N-1:0] mq [$];
  logic [N-1:0] m_q;
  logic         m_qv, m_ovf, m_unf;

  typedef struct {
    logic         rst;
    logic         w;
    logic         r;
    logic [N-1:0] d;
    logic [N-1:0] eq;
    logic         eqv;
    int           ecnt;
    logic         efull;
    logic         eempty;
    logic         eovf;
    logic         eunf;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic rs, input logic w, input logic r, input logic [N-1:0] dv,
                     input logic [N-1:0] eq, input logic eqv, input int ecnt,
                     input logic efull, input logic eempty, input logic eovf, input logic eunf);
    vec_t v;
    v.rst = rs; v.w = w; v.r = r; v.d = dv;
    v.eq = eq; v.eqv = eqv; v.ecnt = ecnt; v.efull = efull; v.eempty = eempty;
    v.eovf = eovf; v.eunf = eunf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model by the FIFO rules, sample #1 after the edge.
  task automatic step(input logic rs, input logic w, input logic r, input logic [N-1:0] dv);
    bit rd, wr;
    rst = rs; w_enable = w; r_enable = r; d = dv;
    if (rs) begin
      mq.delete();
      m_q = '0; m_qv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      rd = r && (mq.size() != 0);
      wr = w && ((mq.size() != DEPTH) || rd);
      if (rd) m_q = mq.pop_front();
      m_qv = rd;
      if (wr) mq.push_back(dv);
      if (w && !wr) m_ovf = 1'b1;
      if (r && !rd) m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},         int'(q),         int'(m_q));
    check({tag, ".q_valid"},   int'(q_valid),   int'(m_qv));
    check({tag, ".count"},     int'(count),     mq.size());
    check({tag, ".full"},      int'(full),      int'(mq.size() == DEPTH));
    check({tag, ".empty"},     int'(empty),     int'(mq.size() == 0));
    check({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
    check({tag, ".underflow"}, int'(underflow), int'(m_unf));
  endtask

  initial begin
    rst = 1'b1; w_enable = 1'b0; r_enable = 1'b0; d = '0;
    m_q = '0; m_qv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    //   rst w  r  d        q        qv cnt full empty ovf unf
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);
    // three writes then three reads
    add(0, 1, 0, 16'h0004, 16'h0000, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 16'h000A, 16'h0000, 0, 2, 0, 0, 0, 0);
    add(0, 1, 0, 16'h00FF, 16'h0000, 0, 3, 0, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 16'h0004, 1, 2, 0, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 16'h000A, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 16'h0000, 16'h00FF, 1, 0, 0, 1, 0, 0);
    // fill, then a rejected fifth write
    add(0, 1, 0, 16'h1111, 16'h00FF, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 16'h2222, 16'h00FF, 0, 2, 0, 0, 0, 0);
    add(0, 1, 0, 16'h3333, 16'h00FF, 0, 3, 0, 0, 0, 0);
    add(0, 1, 0, 16'h4444, 16'h00FF, 0, 4, 1, 0, 0, 0);
    add(0, 1, 0, 16'h5555, 16'h00FF, 0, 4, 1, 0, 1, 0);
    // full with simultaneous read and write
    add(0, 1, 1, 16'hAAAA, 16'h1111, 1, 4, 1, 0, 1, 0);
    add(0, 0, 1, 16'h0000, 16'h2222, 1, 3, 0, 0, 1, 0);
    add(0, 0, 1, 16'h0000, 16'h3333, 1, 2, 0, 0, 1, 0);
    add(0, 0, 1, 16'h0000, 16'h4444, 1, 1, 0, 0, 1, 0);
    add(0, 0, 1, 16'h0000, 16'hAAAA, 1, 0, 0, 1, 1, 0);
    // read on empty: q holds, underflow sticks
    add(0, 0, 1, 16'h0000, 16'hAAAA, 0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);
    // empty with simultaneous read and write: no fall-through
    add(0, 1, 1, 16'hBEEF, 16'h0000, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 16'h0000, 16'hBEEF, 1, 0, 0, 1, 0, 1);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);
    // reset beats a concurrent write and discards contents
    add(0, 1, 0, 16'h0001, 16'h0000, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 16'h0002, 16'h0000, 0, 2, 0, 0, 0, 0);
    add(1, 1, 0, 16'h0C0C, 16'h0000, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].d);
      check({t, ".q"},         int'(q),         int'(vecs[i].eq));
      check({t, ".q_valid"},   int'(q_valid),   int'(vecs[i].eqv));
      check({t, ".count"},     int'(count),     vecs[i].ecnt);
      check({t, ".full"},      int'(full),      int'(vecs[i].efull));
      check({t, ".empty"},     int'(empty),     int'(vecs[i].eempty));
      check({t, ".overflow"},  int'(overflow),  int'(vecs[i].eovf));
      check({t, ".underflow"}, int'(underflow), int'(vecs[i].eunf));
    end

    // Ten write/read pairs: pointers wrap more than twice.
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, 1'b0, N'(i));
      step(1'b0, 1'b0, 1'b1, '0);
      check($sformatf("wrap%0d.q", i), int'(q), i);
      check($sformatf("wrap%0d.q_valid", i), int'(q_valid), 1);
      check($sformatf("wrap%0d.flags", i), int'({overflow, underflow}), 0);
      check($sformatf("wrap%0d.empty", i), int'(empty), 1);
    end

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic rs, w, r;
      rs = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      step(rs, w, r, N'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
